// File: rtl/prog_sequencer_pkg.sv
// Shared types and defaults for the program sequencer.
package prog_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } seq_state_e;

    localparam int unsigned START_PC_DEF = 0;
    // Wait counter holds MEM_LAT-1, MEM_LAT is at most 7.
    localparam int unsigned WAIT_W       = 3;

endpackage

// File: rtl/prog_sequencer_branch_resolve.sv
// Combinational branch resolution: decides taken and picks the next PC.
module prog_sequencer_branch_resolve #(
    parameter int unsigned T = 10
) (
    input  logic         branch_always,
    input  logic         branch_ez,
    input  logic         branch_nz,
    input  logic         acc_zero,
    input  logic [T-1:0] target,
    input  logic [T-1:0] prog_ctr,
    output logic [T-1:0] next_pc_c,
    output logic         taken_c
);

    // All strobes share one target, so strobe priority only shapes taken.
    always_comb begin
        taken_c = 1'b0;
        if (branch_always) begin
            taken_c = 1'b1;
        end else if (branch_ez && acc_zero) begin
            taken_c = 1'b1;
        end else if (branch_nz && !acc_zero) begin
            taken_c = 1'b1;
        end
        next_pc_c = taken_c ? target : prog_ctr + T'(1);
    end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: PC ownership, start/halt control, branch resolution and LDW wait insertion.
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int unsigned T        = 10,
    parameter int unsigned START_PC = START_PC_DEF,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned CW       = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic          Done_in,
    input  logic          BranchEZ,
    input  logic          BranchNZ,
    input  logic          BranchAlways,
    input  logic          LoadReq,
    input  logic          AccZero,
    input  logic [T-1:0]  Target,
    output logic [T-1:0]  ProgCtr,
    output logic [T-1:0]  ProgCtr_p1,
    output logic          CommitEn,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] CycleCount
);

    localparam logic [T-1:0]      START_PC_V = T'(START_PC);
    localparam logic [WAIT_W-1:0] WAIT_INIT  = WAIT_W'((MEM_LAT == 0) ? 0 : MEM_LAT - 1);
    localparam logic [CW-1:0]     CYC_MAX    = {CW{1'b1}};
    localparam bit                HAS_WAIT   = (MEM_LAT != 0);

    seq_state_e        state_q, state_d;
    logic [T-1:0]      pc_q, pc_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic              commit_c;
    logic [T-1:0]      br_next_pc_c;
    logic              br_taken_c;
    logic [T-1:0]      pc_p1_c;

    assign pc_p1_c = pc_q + T'(1);

    prog_sequencer_branch_resolve #(
        .T (T)
    ) u_branch_resolve (
        .branch_always (BranchAlways),
        .branch_ez     (BranchEZ),
        .branch_nz     (BranchNZ),
        .acc_zero      (AccZero),
        .target        (Target),
        .prog_ctr      (pc_q),
        .next_pc_c     (br_next_pc_c),
        .taken_c       (br_taken_c)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= START_PC_V;
            wait_q  <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wait_q  <= wait_d;
            cyc_q   <= cyc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        wait_d   = wait_q;
        cyc_d    = cyc_q;
        commit_c = 1'b0;

        // Saturating count of busy cycles; a Start below clears it.
        if ((state_q == ST_RUN || state_q == ST_WAIT) && cyc_q != CYC_MAX) begin
            cyc_d = cyc_q + CW'(1);
        end

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = START_PC_V;
                    cyc_d   = '0;
                end
            end
            ST_RUN: begin
                commit_c = 1'b1;
                if (Done_in) begin
                    state_d  = ST_HALT;
                    commit_c = 1'b0;
                end else if (LoadReq && HAS_WAIT) begin
                    state_d  = ST_WAIT;
                    wait_d   = WAIT_INIT;
                    commit_c = 1'b0;
                end else begin
                    pc_d = br_next_pc_c;
                end
            end
            ST_WAIT: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end else begin
                    // Data is back: the LDW commits now and the PC moves on.
                    commit_c = 1'b1;
                    pc_d     = pc_p1_c;
                    state_d  = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ProgCtr    = pc_q;
    assign ProgCtr_p1 = pc_p1_c;
    assign CommitEn   = commit_c;
    assign Busy       = (state_q == ST_RUN) || (state_q == ST_WAIT);
    assign Done       = (state_q == ST_HALT);
    assign CycleCount = cyc_q;

    logic unused_taken;
    assign unused_taken = br_taken_c;

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Multi-cycle program sequencer for the 9-bit-instruction core: owns the program counter, starts and stops execution, and resolves branches from the instruction decoder's branch strobes. Inserts wait cycles for LDW so a latency-configurable data memory can return data, and gates register/memory commits while stalled. Sits between the top-level Start/Done handshake, the instruction ROM address, and the decoder's outputs.

Parameters:
T, 10, program counter width (instruction ROM depth 2^T)
START_PC, 0, PC loaded on reset and on every accepted Start
MEM_LAT, 1, extra cycles an LDW waits for mem_out (0..7; 0 = no stall)
CW, 16, width of cycle counter

Ports:
Clk  in  1  single system clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
Start  in  1  level/pulse; accepted only in IDLE or HALT
Done_in  in  1  decoder: DNE instruction
BranchEZ  in  1  decoder: branch if AccZero
BranchNZ  in  1  decoder: branch if !AccZero
BranchAlways  in  1  decoder: unconditional branch (JMP/JAL)
LoadReq  in  1  decoder: current instruction is LDW
AccZero  in  1  accumulator == 0, sampled in the cycle of the branch
Target  in  T  absolute branch target, valid with branch strobes
ProgCtr  out  T  current instruction address to ROM
ProgCtr_p1  out  T  ProgCtr+1 modulo 2^T (JAL link value)
CommitEn  out  1  qualifies RegWrite and write_mem this cycle
Busy  out  1  high in RUN or WAIT
Done  out  1  high in HALT
CycleCount  out  CW  cycles spent in RUN+WAIT since last Start

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (Reset_n=0, immediate): state IDLE, ProgCtr=START_PC, wait counter=0, CycleCount=0; Done=0, Busy=0, CommitEn=0.
- States: IDLE, RUN, WAIT, HALT.
- IDLE: Start=1 -> RUN next cycle, ProgCtr=START_PC, CycleCount=0.
- RUN (one instruction per cycle, combinational ROM): CommitEn=1 unless noted. Priority at clock edge:
  1. Done_in -> HALT; CommitEn=0; ProgCtr holds.
  2. LoadReq and MEM_LAT>0 -> WAIT, wait counter=MEM_LAT-1; CommitEn=0; ProgCtr holds.
  3. Branch taken -> ProgCtr=Target. Taken = BranchAlways | (BranchEZ & AccZero) | (BranchNZ & !AccZero). Multiple strobes: BranchAlways > BranchEZ > BranchNZ.
  4. Otherwise ProgCtr=ProgCtr+1; 2^T-1 wraps to 0.
- WAIT: ProgCtr held, CommitEn=0 while counter>0, counter decrements. When counter==0: CommitEn=1 (LDW writes mem_out), ProgCtr=ProgCtr+1, -> RUN. Total LDW cost = MEM_LAT+1 cycles.
- HALT: Done=1 held, CommitEn=0, ProgCtr frozen. Start=1 -> RUN from START_PC with CycleCount cleared and Done dropping the same edge.
- Start in RUN/WAIT is ignored.
- CycleCount increments every cycle in RUN or WAIT, saturates at 2^CW-1, holds in IDLE/HALT.
- ProgCtr_p1 is combinational from ProgCtr.
- Reset asserted mid-WAIT or mid-RUN aborts immediately to IDLE; no commit issued.

Decomposition:
- Shared package Definitions: seq_state_e enum (IDLE, RUN, WAIT, HALT), START_PC default constant.
- One natural sub-module: branch_resolve (combinational: strobes, AccZero, Target, ProgCtr -> next PC, taken). Counters and FSM stay in prog_sequencer.

Test Plan:
- Reset then Start with START_PC=0, no branches, 5 cycles -> ProgCtr 0,1,2,3,4; CommitEn=1 each cycle; CycleCount=5.
- BranchEZ, Target=0x3A0: AccZero=1 -> ProgCtr=0x3A0 next cycle; AccZero=0 -> ProgCtr+1.
- All three strobes with AccZero=0, Target=0x055 -> ProgCtr=0x055 (BranchAlways wins); ProgCtr=0x3FF, no branch -> ProgCtr=0x000.
- LDW with MEM_LAT=2 at PC=7 -> WAIT 2 cycles, CommitEn 0,1; PC 7,7,8; MEM_LAT=0 -> no WAIT, PC 7->8 in one cycle.
- Done_in at PC=12 with BranchAlways also high -> HALT, Done=1, ProgCtr stays 12; Start pulse -> ProgCtr=START_PC, Done=0, CycleCount=0.
- Reset_n low mid-WAIT -> outputs at reset values before next edge; Start during RUN -> no effect on ProgCtr.
